// File: rtl/output_packet_tx.sv
// Serial frame transmitter: a HEADER_BYTE then 4 buffered payload bytes, MSB first.
// The next byte is prefetched while the current one shifts, so bytes leave back-to-back.
module output_packet_tx #(
  parameter logic [7:0] HEADER_BYTE  = 8'hA5,
  parameter int         CLKS_PER_BIT = 50
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       pkt_ready,
  input  logic [7:0] rd_data,
  output logic       read_buffer,
  output logic       tx_serial,
  output logic       tx_frame,
  output logic       byte_complete,
  output logic       busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          rd_pend_q, rd_pend_d;
  logic          read_buffer_q, read_buffer_d;
  logic          tx_serial_q, tx_serial_d;
  logic          tx_frame_q, tx_frame_d;
  logic          byte_complete_q, byte_complete_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    unique case (state_q)
      IDLE: if (pkt_ready) begin
        state_d    = HEADER;
        shift_d    = HEADER_BYTE;
        byte_idx_d = 2'd0;
        clk_cnt_d  = '0;
        bit_cnt_d  = 3'd7;
      end
      HEADER, DATA: begin
        if (clk_cnt_q == CLK_MAX) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd7;
            if (state_q == HEADER) begin
              state_d    = DATA;
              shift_d    = hold_q;
              byte_idx_d = 2'd0;
            end else if (byte_idx_q != 2'd3) begin
              shift_d    = hold_q;
              byte_idx_d = byte_idx_q + 2'd1;
            end else begin
              state_d = GAP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    tx_frame_d      = (state_d == HEADER) || (state_d == DATA);
    tx_serial_d     = tx_frame_d & shift_d[7];
    busy_d          = (state_d != IDLE);
    byte_complete_d = tx_frame_d && (clk_cnt_d == CLK_MAX) && (bit_cnt_d == 3'd0);
    read_buffer_d   = tx_frame_d && (clk_cnt_d == '0) && (bit_cnt_d == 3'd7) &&
                      ((state_d == HEADER) || (byte_idx_d != 2'd3));
    // Buffer data arrives the cycle after the pop pulse.
    rd_pend_d       = read_buffer_q;
    hold_d          = rd_pend_q ? rd_data : hold_q;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= 3'd0;
      byte_idx_q      <= 2'd0;
      shift_q         <= 8'd0;
      hold_q          <= 8'd0;
      rd_pend_q       <= 1'b0;
      read_buffer_q   <= 1'b0;
      tx_serial_q     <= 1'b0;
      tx_frame_q      <= 1'b0;
      byte_complete_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_idx_q      <= byte_idx_d;
      shift_q         <= shift_d;
      hold_q          <= hold_d;
      rd_pend_q       <= rd_pend_d;
      read_buffer_q   <= read_buffer_d;
      tx_serial_q     <= tx_serial_d;
      tx_frame_q      <= tx_frame_d;
      byte_complete_q <= byte_complete_d;
      busy_q          <= busy_d;
    end
  end

  assign read_buffer   = read_buffer_q;
  assign tx_serial     = tx_serial_q;
  assign tx_frame      = tx_frame_q;
  assign byte_complete = byte_complete_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_output_packet_tx.sv
// Directed bench for output_packet_tx at 4 clocks/bit with a 1-cycle-latency buffer model.
// A second instance with HEADER_BYTE=3C shares the stimulus to check the override.
module tb_output_packet_tx;
  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       pkt_ready;
  logic [7:0] rd_data = 8'h00;
  logic       read_buffer, tx_serial, tx_frame, byte_complete, busy;
  logic       read_buffer2, tx_serial2, tx_frame2, byte_complete2, busy2;

  int checks = 0;
  int failures = 0;
  logic [7:0] bq[$];
  int  pops = 0;
  logic pr_man = 1'b0;
  logic pr_auto = 1'b0;

  always #10 clk_50 = ~clk_50;

  assign pkt_ready = pr_auto ? (bq.size() >= 4) : pr_man;

  output_packet_tx #(.HEADER_BYTE(8'hA5), .CLKS_PER_BIT(4)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .pkt_ready(pkt_ready), .rd_data(rd_data),
    .read_buffer(read_buffer), .tx_serial(tx_serial), .tx_frame(tx_frame),
    .byte_complete(byte_complete), .busy(busy));

  output_packet_tx #(.HEADER_BYTE(8'h3C), .CLKS_PER_BIT(4)) dut2 (
    .clk_50(clk_50), .reset_n(reset_n), .pkt_ready(pkt_ready), .rd_data(rd_data),
    .read_buffer(read_buffer2), .tx_serial(tx_serial2), .tx_frame(tx_frame2),
    .byte_complete(byte_complete2), .busy(busy2));

  always @(posedge clk_50)
    if (read_buffer && bq.size() > 0) begin
      rd_data <= bq.pop_front();
      pops <= pops + 1;
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for tx_frame, then records the frame from its first cycle until tx_frame drops.
  task automatic get_frame(output logic [39:0] d, output logic [7:0] h2, output int len,
                           output int bc, output int rd_ok, output int rd_cnt);
    int t = 0;
    d = '0; h2 = '0; len = 0; bc = 0; rd_ok = 0; rd_cnt = 0;
    while (!tx_frame && t < 2000) begin @(negedge clk_50); t++; end
    while (tx_frame && len < 400) begin
      if (len % 4 == 2) begin
        d = {d[38:0], tx_serial};
        if (len < 32) h2 = {h2[6:0], tx_serial2};
      end
      if (byte_complete) bc += (len % 32 == 31) ? 1 : 100;
      if (read_buffer) begin
        rd_cnt++;
        if (len % 32 == 0 && len < 128) rd_ok++;
      end
      len++;
      @(negedge clk_50);
    end
  endtask

  task automatic count_low(output int g);
    g = 0;
    while (!tx_frame && g < 100) begin g++; @(negedge clk_50); end
  endtask

  task automatic pulse_ready();
    pr_man = 1'b1;
    @(negedge clk_50);
    pr_man = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [39:0] exp);
    logic [39:0] d; logic [7:0] h2; int len, bc, rd_ok, rd_cnt;
    get_frame(d, h2, len, bc, rd_ok, rd_cnt);
    chk({tag, "_data"}, 64'(d), 64'(exp));
    chk({tag, "_len"}, 64'(len), 64'd160);
    chk({tag, "_bc"}, 64'(bc), 64'd5);
    chk({tag, "_rdpos"}, 64'(rd_ok), 64'd4);
    chk({tag, "_rdcnt"}, 64'(rd_cnt), 64'd4);
    chk({tag, "_hdr3c"}, 64'(h2), 64'h3C);
  endtask

  initial begin
    logic [39:0] d; logic [7:0] h2; int len, bc, rd_ok, rd_cnt, g, p0;
    repeat (3) @(negedge clk_50);
    chk("rst_outs", {59'd0, read_buffer, tx_serial, tx_frame, byte_complete, busy}, 64'd0);
    chk("rst_outs2", {62'd0, tx_frame2, busy2}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic frame
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_ready();
    check_frame("basic", 40'hA5_11_22_33_44);
    chk("basic_pops", 64'(pops), 64'd4);
    chk("gap_busy", 64'(busy), 64'd1);
    @(negedge clk_50);
    chk("idle_after", {62'd0, busy, tx_serial}, 64'd0);

    // Boundary payload
    bq = '{8'h00, 8'hFF, 8'h80, 8'h01};
    pulse_ready();
    check_frame("bound", 40'hA5_00_FF_80_01);

    // Back-to-back with pkt_ready held by buffer level
    bq = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB0, 8'hB1};
    p0 = pops;
    pr_auto = 1'b1;
    check_frame("b2b1", 40'hA5_AA_AB_AC_AD);
    count_low(g);
    chk("b2b_gap", 64'(g), 64'd2);
    check_frame("b2b2", 40'hA5_AE_AF_B0_B1);
    repeat (20) @(negedge clk_50);
    pr_auto = 1'b0;
    chk("b2b_pops", 64'(pops - p0), 64'd8);
    chk("b2b_idle", {62'd0, busy, tx_frame}, 64'd0);

    // pkt_ready dropped during 2nd payload byte
    bq = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78};
    p0 = pops;
    pr_man = 1'b1;
    fork
      get_frame(d, h2, len, bc, rd_ok, rd_cnt);
      begin repeat (75) @(negedge clk_50); pr_man = 1'b0; end
    join
    chk("drop_data", 64'(d), 64'hA5_5A_C3_0F_F0);
    chk("drop_len", 64'(len), 64'd160);
    repeat (200) @(negedge clk_50);
    chk("drop_pops", 64'(pops - p0), 64'd4);
    chk("drop_idle", {62'd0, busy, tx_frame}, 64'd0);

    // Reset in the 3rd byte
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_ready();
    repeat (80) @(negedge clk_50);
    chk("pre_rst_frame", 64'(tx_frame), 64'd1);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst", {61'd0, tx_frame, tx_serial, busy}, 64'd0);
    @(negedge clk_50);
    bq.delete();
    reset_n = 1'b1;
    @(negedge clk_50);
    bq = '{8'h9C, 8'h6E, 8'h3B, 8'hD7};
    pulse_ready();
    check_frame("post_rst", 40'hA5_9C_6E_3B_D7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
